demod_integrator: RTL

Downstream stage of the demodulation `multiplier`. It consumes the five-lane rotated I/Q words each `clk100` cycle and sums all lanes over a readout window of `sample_length` cycles. It then presents one signed I sum and one signed Q sum per window, with a single-cycle valid strobe. This feeds the readout/discrimination logic.

---
 rtl/demod_integrator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/demod_integrator.sv
// Window integrator: sums all I/Q lanes over sample_length words, one strobe per window.
// Optional saturating accumulators and sat_flag under `DEMOD_INTEG_SAT_EN.
module demod_integrator #(
  parameter int LANES = 5,
  parameter int DW    = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk100,
  input  logic                    reset,
  input  logic                    start_collect,
  input  logic [10:0]             sample_length,
  input  logic [LANES*DW-1:0]     data_i_rot,
  input  logic [LANES*DW-1:0]     data_q_rot,
  output logic                    busy,
  output logic                    result_valid,
  output logic signed [ACC_W-1:0] i_sum,
  output logic signed [ACC_W-1:0] q_sum,
  output logic                    sat_flag
);
  localparam int SW = DW + 3;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                  state;
  logic [10:0]             len, cnt;
  logic                    zero_len;
  logic signed [SW-1:0]    lane_i, lane_q, s1_i, s1_q;
  logic                    s1_vld, s1_first;
  logic signed [ACC_W-1:0] acc_i, acc_q, nxt_i, nxt_q;
  logic                    start_ok, accept;

  assign start_ok = (state == IDLE) && start_collect;
  assign accept   = (start_ok && sample_length != 11'd0) || (state == ACCUM);

  always_comb begin
    lane_i = '0;
    lane_q = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_i = lane_i + SW'($signed(data_i_rot[k*DW +: DW]));
      lane_q = lane_q + SW'($signed(data_q_rot[k*DW +: DW]));
    end
  end

`ifdef DEMOD_INTEG_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] sum_i, sum_q;
  logic                  clamp_i, clamp_q, sat_acc;

  // One guard bit; a mismatch between the top two bits is an overflow.
  always_comb begin
    sum_i   = s1_first ? (ACC_W+1)'(s1_i) : (ACC_W+1)'(acc_i) + (ACC_W+1)'(s1_i);
    sum_q   = s1_first ? (ACC_W+1)'(s1_q) : (ACC_W+1)'(acc_q) + (ACC_W+1)'(s1_q);
    clamp_i = sum_i[ACC_W] ^ sum_i[ACC_W-1];
    clamp_q = sum_q[ACC_W] ^ sum_q[ACC_W-1];
    nxt_i   = clamp_i ? (sum_i[ACC_W] ? ACC_MIN : ACC_MAX) : sum_i[ACC_W-1:0];
    nxt_q   = clamp_q ? (sum_q[ACC_W] ? ACC_MIN : ACC_MAX) : sum_q[ACC_W-1:0];
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      sat_acc  <= 1'b0;
      sat_flag <= 1'b0;
    end else if (start_ok) begin
      sat_acc  <= 1'b0;
      sat_flag <= 1'b0;
    end else if (s1_vld) begin
      sat_acc <= sat_acc | clamp_i | clamp_q;
      if (state == DRAIN) sat_flag <= sat_acc | clamp_i | clamp_q;
    end
  end
`else
  always_comb begin
    nxt_i = s1_first ? ACC_W'(s1_i) : acc_i + ACC_W'(s1_i);
    nxt_q = s1_first ? ACC_W'(s1_q) : acc_q + ACC_W'(s1_q);
  end

  assign sat_flag = 1'b0;
`endif

  always_ff @(posedge clk100) begin
    if (reset) begin
      state        <= IDLE;
      len          <= '0;
      cnt          <= '0;
      zero_len     <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      i_sum        <= '0;
      q_sum        <= '0;
      s1_vld       <= 1'b0;
      s1_first     <= 1'b0;
      s1_i         <= '0;
      s1_q         <= '0;
      acc_i        <= '0;
      acc_q        <= '0;
    end else begin
      result_valid <= 1'b0;
      s1_vld       <= accept;
      s1_first     <= start_ok;
      s1_i         <= lane_i;
      s1_q         <= lane_q;
      if (s1_vld) begin
        acc_i <= nxt_i;
        acc_q <= nxt_q;
      end
      case (state)
        IDLE: begin
          busy <= start_collect;
          if (start_collect) begin
            len      <= sample_length;
            cnt      <= 11'd1;
            zero_len <= (sample_length == 11'd0);
            // An empty window reports immediately; DRAIN then only closes it.
            if (sample_length == 11'd0) begin
              state        <= DRAIN;
              result_valid <= 1'b1;
              i_sum        <= '0;
              q_sum        <= '0;
            end else if (sample_length == 11'd1) begin
              state <= DRAIN;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          cnt <= cnt + 11'd1;
          if (cnt + 11'd1 == len) state <= DRAIN;
        end
        DRAIN: begin
          state <= IDLE;
          busy  <= !zero_len;
          if (!zero_len) begin
            result_valid <= 1'b1;
            i_sum        <= nxt_i;
            q_sum        <= nxt_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
